// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer, in-order instruction-memory request/response tracking and fetch queue.
// Revision: 1.0
`default_nettype none

module fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [ADDR_W-1:0] if_pc,
   output logic [31:0]       if_instr,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] pc;
   logic [PTR_W-1:0]  alloc_ptr, fill_ptr, rd_ptr;
   logic [CNT_W-1:0]  alloc_cnt, pend_cnt, drop_cnt;
   logic [ADDR_W-1:0] ent_pc    [DEPTH];
   logic [31:0]       ent_instr [DEPTH];
   logic [DEPTH-1:0]  ent_filled;

   logic [CNT_W:0]    occupancy;
   logic [CNT_W:0]    outstanding;
   logic              accept, live_fill, stale_drop, deliver;
   logic              unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Stale responses still occupy memory slots, so they count against the queue.
   assign occupancy   = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
   assign outstanding = {1'b0, pend_cnt} + {1'b0, drop_cnt};

   assign imem_req   = rst_n && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
   assign imem_addr  = pc;
   assign accept     = imem_req && imem_ready;
   assign stale_drop = imem_rvalid && (drop_cnt != '0);
   assign live_fill  = imem_rvalid && (drop_cnt == '0) && (pend_cnt != '0);

   assign if_valid = ent_filled[rd_ptr];
   assign if_pc    = ent_pc[rd_ptr];
   assign if_instr = ent_instr[rd_ptr];
   assign deliver  = if_valid && if_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         alloc_ptr  <= '0;
         fill_ptr   <= '0;
         rd_ptr     <= '0;
         alloc_cnt  <= '0;
         pend_cnt   <= '0;
         drop_cnt   <= '0;
         ent_filled <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_pc[i]    <= '0;
            ent_instr[i] <= '0;
         end
      end else if (redirect_valid) begin
         // Any response arriving this cycle is discarded and retires one outstanding read.
         pc         <= {redirect_pc[ADDR_W-1:2], 2'b00};
         alloc_ptr  <= '0;
         fill_ptr   <= '0;
         rd_ptr     <= '0;
         alloc_cnt  <= '0;
         pend_cnt   <= '0;
         ent_filled <= '0;
         drop_cnt   <= CNT_W'(outstanding - (CNT_W+1)'(imem_rvalid && (outstanding != '0)));
      end else begin
         if (accept) begin
            ent_pc[alloc_ptr]     <= pc;
            ent_filled[alloc_ptr] <= 1'b0;
            alloc_ptr             <= alloc_ptr + PTR_W'(1);
            pc                    <= pc + ADDR_W'(4);
         end
         if (live_fill) begin
            ent_instr[fill_ptr]  <= imem_rdata;
            ent_filled[fill_ptr] <= 1'b1;
            fill_ptr             <= fill_ptr + PTR_W'(1);
         end
         if (stale_drop) begin
            drop_cnt <= drop_cnt - CNT_W'(1);
         end
         if (deliver) begin
            ent_filled[rd_ptr] <= 1'b0;
            rd_ptr             <= rd_ptr + PTR_W'(1);
         end
         alloc_cnt <= alloc_cnt + CNT_W'(accept) - CNT_W'(deliver);
         pend_cnt  <= pend_cnt + CNT_W'(accept) - CNT_W'(live_fill);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit with a latency-programmable memory model.
// Revision: 1.0
`default_nettype none

module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;
   int lat    = 1;

   fetch_unit #(
      .ADDR_W  (32),
      .RESET_PC(32'h0000_0000),
      .DEPTH   (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_ready      (if_ready),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // In-order memory: a request seen at the falling edge is accepted on the next rising edge,
   // and its data is presented lat falling edges later.
   logic [31:0] mq_addr[$];
   int          mq_cnt[$];
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mq_addr.delete();
            mq_cnt.delete();
            imem_rvalid = 1'b0;
         end else begin
            foreach (mq_cnt[i]) mq_cnt[i] = mq_cnt[i] - 1;
            imem_rvalid = 1'b0;
            if (mq_cnt.size() > 0 && mq_cnt[0] <= 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mq_addr[0] ^ 32'hA5A5_0000;
               void'(mq_addr.pop_front());
               void'(mq_cnt.pop_front());
            end
            if (imem_req && imem_ready) begin
               mq_addr.push_back(imem_addr);
               mq_cnt.push_back(lat);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench one time unit after a rising edge, inside cycle 1 after release.
   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_ready     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        rdy;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl[21];

   initial begin
      int accepts;
      int n;
      bit got;
      bit req_seen;

      // Streaming from reset with 1-cycle memory, then decode stall, then release.
      tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
      tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
      tbl[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
      tbl[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
      tbl[7]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
      for (int i = 8; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
      tbl[16] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10};
      tbl[17] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
      tbl[18] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
      tbl[19] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
      tbl[20] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

      if_ready = 1'b1;
      lat      = 1;
      do_reset();
      for (int i = 0; i < 21; i++) begin
         if_ready = tbl[i].rdy;
         sample();
         chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].exp_req});
         if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
         chk($sformatf("tbl%0d_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].exp_valid});
         if (tbl[i].exp_valid) begin
            chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_instr", i), if_instr, tbl[i].exp_pc ^ 32'hA5A5_0000);
         end
         next_cycle();
      end

      // Memory not ready: the request holds its address.
      do_reset();
      imem_ready = 1'b0;
      sample();
      chk("stall_c1_addr", imem_addr, 32'h0);
      next_cycle();
      imem_ready = 1'b1;
      sample();
      chk("stall_c2_req", {31'b0, imem_req}, 32'h1);
      chk("stall_c2_addr", imem_addr, 32'h0);
      next_cycle();
      sample();
      chk("stall_c3_addr", imem_addr, 32'h4);
      next_cycle();

      // Backpressure from reset: exactly DEPTH accepts, then in-order drain.
      if_ready = 1'b0;
      do_reset();
      accepts = 0;
      for (int i = 0; i < 10; i++) begin
         sample();
         if (imem_req && imem_ready) begin
            chk("bp_accept_addr", imem_addr, 32'(4 * accepts));
            accepts++;
         end
         next_cycle();
      end
      chk("bp_accept_count", 32'(accepts), 32'd4);
      if_ready = 1'b1;
      n        = 0;
      req_seen = 1'b0;
      for (int i = 0; i < 20 && n < 4; i++) begin
         sample();
         if (imem_req && !req_seen) begin
            chk("bp_next_req_addr", imem_addr, 32'h10);
            req_seen = 1'b1;
         end
         if (if_valid) begin
            chk("bp_drain_pc", if_pc, 32'(4 * n));
            n++;
         end
         next_cycle();
      end
      chk("bp_drain_count", 32'(n), 32'd4);

      // Asynchronous reset mid-stream while the queue is full.
      if_ready = 1'b0;
      repeat (6) next_cycle();
      chk("rst_pre_valid", {31'b0, if_valid}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_req", {31'b0, imem_req}, 32'h0);
      chk("rst_async_valid", {31'b0, if_valid}, 32'h0);
      chk("rst_async_pc", if_pc, 32'h0);
      chk("rst_async_instr", if_instr, 32'h0);
      do_reset();
      sample();
      chk("rst_restart_req", {31'b0, imem_req}, 32'h1);
      chk("rst_restart_addr", imem_addr, 32'h0);
      next_cycle();

      // Redirect with three reads in flight on a slow memory.
      if_ready = 1'b1;
      lat      = 4;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("redir_pre_addr", imem_addr, 32'(4 * i));
         next_cycle();
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      sample();
      chk("redir_req_low", {31'b0, imem_req}, 32'h0);
      next_cycle();
      redirect_valid = 1'b0;
      sample();
      chk("redir_new_req", {31'b0, imem_req}, 32'h1);
      chk("redir_new_addr", imem_addr, 32'h100);
      next_cycle();
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         sample();
         if (if_valid) begin
            chk("redir_first_pc", if_pc, 32'h100);
            chk("redir_first_instr", if_instr, 32'h100 ^ 32'hA5A5_0000);
            got = 1'b1;
         end
         next_cycle();
      end
      if (!got) chk("redir_first_timeout", 32'h0, 32'h1);

      // Redirect coinciding with a delivery handshake and a live response.
      lat = 1;
      do_reset();
      repeat (4) next_cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      sample();
      chk("sim_head_valid", {31'b0, if_valid}, 32'h1);
      chk("sim_head_pc", if_pc, 32'h8);
      chk("sim_req_low", {31'b0, imem_req}, 32'h0);
      next_cycle();
      redirect_valid = 1'b0;
      sample();
      chk("sim_c6_valid", {31'b0, if_valid}, 32'h0);
      chk("sim_c6_addr", imem_addr, 32'h200);
      next_cycle();
      sample();
      chk("sim_c7_valid", {31'b0, if_valid}, 32'h0);
      next_cycle();
      sample();
      chk("sim_c8_valid", {31'b0, if_valid}, 32'h1);
      chk("sim_c8_pc", if_pc, 32'h200);
      next_cycle();

      // PC wrap across the top of the address space.
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      sample();
      chk("wrap_req_low", {31'b0, imem_req}, 32'h0);
      next_cycle();
      redirect_valid = 1'b0;
      sample();
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
      next_cycle();
      sample();
      chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
      next_cycle();
      sample();
      chk("wrap_addr2", imem_addr, 32'h0000_0000);
      chk("wrap_head_pc", if_pc, 32'hFFFF_FFF8);
      chk("wrap_head_valid", {31'b0, if_valid}, 32'h1);
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
